bus_scheduler: RTL

BUS_SCHEDULER -- requirements
Module: bus_scheduler

---
 rtl/bus_scheduler_pkg.sv | 19 +
 rtl/bus_scheduler_arbiter.sv | 29 ++
 rtl/bus_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bus_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// bus_scheduler_pkg
// This package holds the types and constants shared by bus_scheduler and
// rr_arbiter2:
//   state_t      : scheduler FSM states (IDLE, ACCESS, DONE)
//   CORE0, CORE1 : index values of the two requesting cores
// -----------------------------------------------------------------------------
package bus_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/bus_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// This module is the combinational two-way arbitration decision.
// When only one core requests, that core wins. When both cores request, the
// core indexed by token wins.
// Ports:
//   req    [1:0] in  : per-core request, bit n = core n
//   token        in  : preferred core under contention
//   winner [1:0] out : one-hot winner, 00 when nobody requests
// -----------------------------------------------------------------------------
module rr_arbiter2
    import bus_scheduler_pkg::*;
(
    input  logic [1:0] req,
    input  logic       token,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = (token == CORE1) ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_scheduler.sv
// -----------------------------------------------------------------------------
// bus_scheduler
// This module shares one memory bus between two cores. The FSM runs
// IDLE -> ACCESS -> DONE -> IDLE. rr_arbiter2 picks the winning core.
//
// Optional feature: define BUS_LOCK_EN to add the lock port. When the
// owner holds its lock bit in DONE, that owner keeps priority for the next
// arbitration.
//
// Ports:
//   clk, reset (async, active-high)
//   req[1:0], adr0/adr1, wdata0/wdata1, we0/we1 : core requests
//   lock[1:0]                                   : bus lock (BUS_LOCK_EN only)
//   grant[1:0]                                  : registered one-hot bus owner
//   ack[1:0]                                    : one-cycle completion pulse
//   rdata                                       : read data captured at completion
//   mem_adr, mem_wdata, mem_we, mem_valid       : registered memory request
//   mem_ready, mem_rdata                        : memory completion and read data
//   busy                                        : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module bus_scheduler
    import bus_scheduler_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
`ifdef BUS_LOCK_EN
    input  logic [1:0]       lock,
`endif
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we0,
    input  logic             we1,
    output logic [1:0]       grant,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_valid,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    state_t           r_state;
    logic [1:0]       r_grant;
    logic [1:0]       r_ack;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] r_mem_adr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic             r_mem_we;
    logic             r_mem_valid;
    logic             r_token;
    logic             r_owner;   // index of the current owner, kept through DONE

    logic [1:0]       w_winner;
    logic             w_win_idx;
    logic [WIDTH-1:0] w_sel_adr;
    logic [WIDTH-1:0] w_sel_wdata;
    logic             w_sel_we;

    rr_arbiter2 u_arbiter (
        .req    (req),
        .token  (r_token),
        .winner (w_winner)
    );

    assign w_win_idx   = (w_winner == 2'b10) ? CORE1 : CORE0;
    assign w_sel_adr   = (w_win_idx == CORE1) ? adr1   : adr0;
    assign w_sel_wdata = (w_win_idx == CORE1) ? wdata1 : wdata0;
    assign w_sel_we    = (w_win_idx == CORE1) ? we1    : we0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_ack       <= 2'b00;
            r_rdata     <= '0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_valid <= 1'b0;
            r_token     <= CORE0;
            r_owner     <= CORE0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_state     <= ACCESS;
                        r_grant     <= w_winner;
                        r_owner     <= w_win_idx;
                        r_mem_valid <= 1'b1;
                        // The MSB of the address carries the owning core.
                        r_mem_adr   <= {w_win_idx, w_sel_adr[WIDTH-2:0]};
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_we    <= w_sel_we;
                    end
                end
                ACCESS: begin
                    // The payload holds until memory completes the access.
                    if (mem_ready) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_state     <= DONE;
                        r_mem_valid <= 1'b0;
                        r_grant     <= 2'b00;
                        r_mem_adr   <= '0;
                        r_mem_wdata <= '0;
                        r_mem_we    <= 1'b0;
                        r_ack       <= (r_owner == CORE1) ? 2'b10 : 2'b01;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ack   <= 2'b00;
`ifdef BUS_LOCK_EN
                    // A locked owner keeps the token, so it also wins
                    // under contention.
                    if (lock[r_owner]) begin
                        r_token <= r_owner;
                    end else begin
                        r_token <= ~r_owner;
                    end
`else
                    r_token <= ~r_owner;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_valid = r_mem_valid;
    assign busy      = (r_state != IDLE);

endmodule
